// File: rtl/ahb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_pkg
//  Description : Shared AHB-Lite constants, the command record carried by the
//                address slot, and a size-to-byte-mask helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package ahb_pkg;

    // Command address width; the master's ADDR_W parameter must match it
    // because the address slot stores a cmd_t.
    localparam int CMD_ADDR_W = 8;
    localparam int BUS_W      = 32;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [1:0] HSIZE_BYTE = 2'd0;
    localparam logic [1:0] HSIZE_HALF = 2'd1;
    localparam logic [1:0] HSIZE_WORD = 2'd2;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    typedef struct packed {
        logic                  write;
        logic [CMD_ADDR_W-1:0] addr;
        logic [1:0]            size;
        logic [BUS_W-1:0]      wdata;
    } cmd_t;

    // Right-justified mask covering the bytes of one transfer of 'size'.
    function automatic logic [BUS_W-1:0] size_mask(input logic [1:0] size);
        logic [BUS_W-1:0] m;
        case (size)
            HSIZE_BYTE: m = 32'h0000_00FF;
            HSIZE_HALF: m = 32'h0000_FFFF;
            default:    m = 32'hFFFF_FFFF;
        endcase
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ahb_lane_steer.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_lane_steer
//  Description : Combinational byte-lane handling for the AHB-Lite master.
//                - write path: mask to size, shift onto the addressed lanes
//                - read path : shift addressed lanes down, mask (zero-extend)
//                - alignment : flags misaligned half/word and illegal size 3
//  Ports       : i_wr_addr/i_wr_size/i_wr_data -> o_wr_lanes
//                i_rd_addr/i_rd_size/i_rd_data -> o_rd_value
//                i_chk_addr/i_chk_size         -> o_misaligned
//  Revision    : 1.0 - initial release
// ============================================================================
module ahb_lane_steer
    import ahb_pkg::*;
(
    input  logic [1:0]       i_wr_addr,
    input  logic [1:0]       i_wr_size,
    input  logic [BUS_W-1:0] i_wr_data,
    output logic [BUS_W-1:0] o_wr_lanes,
    input  logic [1:0]       i_rd_addr,
    input  logic [1:0]       i_rd_size,
    input  logic [BUS_W-1:0] i_rd_data,
    output logic [BUS_W-1:0] o_rd_value,
    input  logic [1:0]       i_chk_addr,
    input  logic [1:0]       i_chk_size,
    output logic             o_misaligned
);

    // Byte offset times eight gives the bit shift.
    assign o_wr_lanes = (i_wr_data & size_mask(i_wr_size)) << {i_wr_addr, 3'b000};
    assign o_rd_value = (i_rd_data >> {i_rd_addr, 3'b000}) & size_mask(i_rd_size);

    always_comb begin
        o_misaligned = 1'b0;
        case (i_chk_size)
            HSIZE_BYTE: o_misaligned = 1'b0;
            HSIZE_HALF: o_misaligned = i_chk_addr[0];
            HSIZE_WORD: o_misaligned = |i_chk_addr;
            default:    o_misaligned = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/ahb_lite_master_cdl.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_lite_master_cdl
//  Description : AHB-Lite single-transfer master. Commands are accepted into
//                an address slot (A), move to a data slot (D) when the address
//                phase completes, and produce one response pulse each, in order.
//  Ports       : clk, n_rst (async, active low)
//                cmd_*  : command stream in (valid/ready handshake)
//                rsp_*  : response pulse out (no backpressure)
//                h*     : AHB-Lite master interface, all outputs registered
//  Revision    : 1.0 - initial release
// ============================================================================
module ahb_lite_master_cdl
    import ahb_pkg::*;
#(
    parameter int ADDR_W = CMD_ADDR_W,   // must equal CMD_ADDR_W (>= 2)
    parameter int DATA_W = BUS_W         // only 32 supported
)(
    input  logic              clk,
    input  logic              n_rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [1:0]        cmd_size,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_error,
    output logic              hsel,
    output logic [ADDR_W-1:0] haddr,
    output logic [1:0]        hsize,
    output logic [1:0]        htrans,
    output logic [2:0]        hburst,
    output logic              hwrite,
    output logic [DATA_W-1:0] hwdata,
    input  logic [DATA_W-1:0] hrdata,
    input  logic              hresp,
    input  logic              hready
);

    // Address slot. A "local" entry is a misaligned/illegal command: it keeps
    // its place in the pipeline for ordering but is never driven as NONSEQ.
    cmd_t              r_a_cmd;
    logic              r_a_valid;
    logic              r_a_local;

    // Data slot: only what the response needs.
    logic              r_d_valid;
    logic              r_d_local;
    logic              r_d_write;
    logic [1:0]        r_d_addr_lo;
    logic [1:0]        r_d_size;

    logic [1:0]        r_htrans;
    logic              r_hsel;
    logic [DATA_W-1:0] r_hwdata;
    logic              r_rsp_valid;
    logic              r_rsp_error;
    logic [DATA_W-1:0] r_rsp_rdata;

    cmd_t              w_cmd;
    logic              w_cmd_misaligned;
    logic              w_cmd_ready;
    logic              w_accept;
    logic              w_a_done;
    logic              w_d_done;
    logic              w_a_valid_nxt;
    logic              w_a_local_nxt;
    logic              w_err_first;
    logic              w_issue;
    logic [DATA_W-1:0] w_wr_lanes;
    logic [DATA_W-1:0] w_rd_value;

    ahb_lane_steer u_lane_steer (
        .i_wr_addr    (r_a_cmd.addr[1:0]),
        .i_wr_size    (r_a_cmd.size),
        .i_wr_data    (r_a_cmd.wdata),
        .o_wr_lanes   (w_wr_lanes),
        .i_rd_addr    (r_d_addr_lo),
        .i_rd_size    (r_d_size),
        .i_rd_data    (hrdata),
        .o_rd_value   (w_rd_value),
        .i_chk_addr   (cmd_addr[1:0]),
        .i_chk_size   (cmd_size),
        .o_misaligned (w_cmd_misaligned)
    );

    always_comb begin
        w_cmd       = '0;
        w_cmd.write = cmd_write;
        w_cmd.addr  = cmd_addr;
        w_cmd.size  = cmd_size;
        w_cmd.wdata = cmd_wdata;
    end

    // The address phase (bus or local) completes only on an OKAY ready edge;
    // the data phase completes on any ready edge, including the second
    // cycle of an ERROR response, which is what leaves A retained.
    assign w_a_done    = r_a_valid && hready && !hresp;
    assign w_d_done    = r_d_valid && hready;
    assign w_cmd_ready = !hresp && (!r_a_valid || hready);
    assign w_accept    = cmd_valid && w_cmd_ready;

    assign w_a_valid_nxt = w_accept || (r_a_valid && !w_a_done);
    assign w_a_local_nxt = w_accept ? w_cmd_misaligned : r_a_local;

    // First ERROR cycle: master must drop to IDLE for the following cycle.
    assign w_err_first = hresp && !hready;
    assign w_issue     = !w_err_first && w_a_valid_nxt && !w_a_local_nxt;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_a_cmd     <= '0;
            r_a_valid   <= 1'b0;
            r_a_local   <= 1'b0;
            r_d_valid   <= 1'b0;
            r_d_local   <= 1'b0;
            r_d_write   <= 1'b0;
            r_d_addr_lo <= 2'b00;
            r_d_size    <= 2'b00;
            r_htrans    <= HTRANS_IDLE;
            r_hsel      <= 1'b0;
            r_hwdata    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_error <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            if (w_accept) begin
                r_a_cmd   <= w_cmd;
                r_a_valid <= 1'b1;
                r_a_local <= w_cmd_misaligned;
            end else if (w_a_done) begin
                r_a_valid <= 1'b0;
            end

            // hwdata only changes on a completing edge, so it holds through
            // wait states and through an ERROR response.
            if (w_a_done) begin
                r_d_valid   <= 1'b1;
                r_d_local   <= r_a_local;
                r_d_write   <= r_a_cmd.write;
                r_d_addr_lo <= r_a_cmd.addr[1:0];
                r_d_size    <= r_a_cmd.size;
                r_hwdata    <= (r_a_cmd.write && !r_a_local) ? w_wr_lanes : '0;
            end else if (w_d_done) begin
                r_d_valid   <= 1'b0;
            end

            r_htrans <= w_issue ? HTRANS_NONSEQ : HTRANS_IDLE;
            r_hsel   <= w_issue;

            r_rsp_valid <= w_d_done;
            if (w_d_done) begin
                r_rsp_error <= r_d_local || hresp;
                r_rsp_rdata <= (r_d_local || hresp || r_d_write) ? '0 : w_rd_value;
            end else begin
                r_rsp_error <= 1'b0;
                r_rsp_rdata <= '0;
            end
        end
    end

    assign cmd_ready = w_cmd_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_error = r_rsp_error;
    assign hsel      = r_hsel;
    assign haddr     = r_a_cmd.addr;
    assign hsize     = r_a_cmd.size;
    assign htrans    = r_htrans;
    assign hburst    = HBURST_SINGLE;
    assign hwrite    = r_a_cmd.write;
    assign hwdata    = r_hwdata;

endmodule
`default_nettype wire
